editor_hora: RTL and testbench



---
 rtl/editor_hora_pkg.sv | 25 ++
 rtl/editor_hora_bcd_inc_dec.sv | 35 +++
 rtl/editor_hora.sv | 183 ++++++++++++++++++
 tb/tb_editor_hora.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/editor_hora_pkg.sv
// Shared definitions for the time-setting editor: FSM states, field codes
// and BCD limits. Optional blink output is enabled with the PARPADEO_EN macro
// in the top module.
package editor_hora_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    CARGA    = 2'd1,
    EDITAR   = 2'd2,
    ESCRIBIR = 2'd3
  } estado_e;

  localparam logic [1:0] CAMPO_SEG  = 2'd0;
  localparam logic [1:0] CAMPO_MIN  = 2'd1;
  localparam logic [1:0] CAMPO_HORA = 2'd2;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MIN    = 8'h00;

  // True when both nibbles hold a decimal digit.
  function automatic logic es_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/editor_hora_bcd_inc_dec.sv
// Combinational BCD increment/decrement with wrap between min_i and max_i.
// Values that are not valid BCD, or lie outside [min_i, max_i], snap to min_i.
module editor_hora_bcd_inc_dec
  import editor_hora_pkg::*;
(
  input  logic [7:0] valor_i,
  input  logic [7:0] max_i,
  input  logic [7:0] min_i,
  input  logic       subir_i,
  output logic [7:0] valor_o
);

  // Next BCD value: carry/borrow between digits, wrap at the field limits.
  always_comb begin
    valor_o = valor_i;
    if (!es_bcd(valor_i) || (valor_i > max_i) || (valor_i < min_i)) begin
      valor_o = min_i;
    end else if (subir_i) begin
      if (valor_i == max_i)
        valor_o = min_i;
      else if (valor_i[3:0] == 4'd9)
        valor_o = {valor_i[7:4] + 4'd1, 4'd0};
      else
        valor_o = {valor_i[7:4], valor_i[3:0] + 4'd1};
    end else begin
      if (valor_i == min_i)
        valor_o = max_i;
      else if (valor_i[3:0] == 4'd0)
        valor_o = {valor_i[7:4] - 4'd1, 4'd9};
      else
        valor_o = {valor_i[7:4], valor_i[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/editor_hora.sv
// Time-setting editor between the push-button debouncers and the RTC bus
// controller. Transparent in REPOSO; in programming mode it edits a BCD copy
// of hh:mm:ss and requests a one-cycle RTC write on exit.
// Optional macro PARPADEO_EN adds DIV_PARPADEO and the parpadeo blink output.
module editor_hora
  import editor_hora_pkg::*;
#(
  parameter logic [7:0] HORA_MAX = 8'h23,
  parameter logic [7:0] MIN_HORA = 8'h00
`ifdef PARPADEO_EN
  ,
  parameter int unsigned DIV_PARPADEO = 25_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic [7:0] hora_rtc,
  input  logic [7:0] min_rtc,
  input  logic [7:0] seg_rtc,
  output logic [7:0] hora_out,
  output logic [7:0] min_out,
  output logic [7:0] seg_out,
  output logic [1:0] campo_sel,
  output logic       modo_prog,
  output logic       escribir
`ifdef PARPADEO_EN
  ,
  output logic       parpadeo
`endif
);

  estado_e    estado_q, estado_d;
  logic [7:0] hora_q, hora_d;
  logic [7:0] min_q, min_d;
  logic [7:0] seg_q, seg_d;
  logic [1:0] campo_q, campo_d;

  logic       acc_prog, acc_arriba, acc_abajo, acc_izq, acc_der;
  logic [7:0] campo_val, campo_max, campo_min, campo_nuevo;

  // One action per cycle in EDITAR; lower-priority pulses are dropped.
  always_comb begin
    acc_prog   = (estado_q == EDITAR) && btn_prog;
    acc_arriba = (estado_q == EDITAR) && !btn_prog && btn_arriba;
    acc_abajo  = (estado_q == EDITAR) && !btn_prog && !btn_arriba && btn_abajo;
    acc_izq    = (estado_q == EDITAR) && !btn_prog && !btn_arriba && !btn_abajo
                 && btn_izq;
    acc_der    = (estado_q == EDITAR) && !btn_prog && !btn_arriba && !btn_abajo
                 && !btn_izq && btn_der;
  end

  // Route the selected field and its limits to the shared BCD stepper.
  always_comb begin
    campo_val = seg_q;
    campo_max = BCD_MAX_MS;
    campo_min = BCD_MIN;
    case (campo_q)
      CAMPO_HORA: begin
        campo_val = hora_q;
        campo_max = HORA_MAX;
        campo_min = MIN_HORA;
      end
      CAMPO_MIN: begin
        campo_val = min_q;
      end
      default: begin
        campo_val = seg_q;
      end
    endcase
  end

  editor_hora_bcd_inc_dec u_bcd (
    .valor_i (campo_val),
    .max_i   (campo_max),
    .min_i   (campo_min),
    .subir_i (acc_arriba),
    .valor_o (campo_nuevo)
  );

  // Next-state and edit-register update.
  always_comb begin
    estado_d = estado_q;
    hora_d   = hora_q;
    min_d    = min_q;
    seg_d    = seg_q;
    campo_d  = campo_q;
    case (estado_q)
      REPOSO: begin
        if (btn_prog) estado_d = CARGA;
      end
      CARGA: begin
        hora_d   = hora_rtc;
        min_d    = min_rtc;
        seg_d    = seg_rtc;
        campo_d  = CAMPO_SEG;
        estado_d = EDITAR;
      end
      EDITAR: begin
        if (acc_prog) begin
          estado_d = ESCRIBIR;
        end else if (acc_arriba || acc_abajo) begin
          case (campo_q)
            CAMPO_HORA: hora_d = campo_nuevo;
            CAMPO_MIN:  min_d  = campo_nuevo;
            default:    seg_d  = campo_nuevo;
          endcase
        end else if (acc_izq) begin
          campo_d = (campo_q == CAMPO_HORA) ? CAMPO_SEG : campo_q + 2'd1;
        end else if (acc_der) begin
          campo_d = (campo_q == CAMPO_SEG) ? CAMPO_HORA : campo_q - 2'd1;
        end
      end
      ESCRIBIR: begin
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // State and edit registers; reset abandons any edit in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      hora_q   <= MIN_HORA;
      min_q    <= BCD_MIN;
      seg_q    <= BCD_MIN;
      campo_q  <= CAMPO_SEG;
    end else begin
      estado_q <= estado_d;
      hora_q   <= hora_d;
      min_q    <= min_d;
      seg_q    <= seg_d;
      campo_q  <= campo_d;
    end
  end

  // Display mux and mode/write flags; RTC time passes through until edit starts.
  always_comb begin
    modo_prog = (estado_q != REPOSO);
    escribir  = (estado_q == ESCRIBIR);
    campo_sel = campo_q;
    if ((estado_q == REPOSO) || (estado_q == CARGA)) begin
      hora_out = hora_rtc;
      min_out  = min_rtc;
      seg_out  = seg_rtc;
    end else begin
      hora_out = hora_q;
      min_out  = min_q;
      seg_out  = seg_q;
    end
  end

`ifdef PARPADEO_EN
  logic [31:0] div_cnt_q;
  logic        parpadeo_q;

  // Blink divider: free-runs while editing, restarts visible on every value change.
  always_ff @(posedge clk) begin
    if (reset || (estado_q == REPOSO)) begin
      div_cnt_q  <= '0;
      parpadeo_q <= 1'b1;
    end else if (acc_arriba || acc_abajo) begin
      div_cnt_q  <= '0;
      parpadeo_q <= 1'b1;
    end else if (div_cnt_q == 32'(DIV_PARPADEO - 1)) begin
      div_cnt_q  <= '0;
      parpadeo_q <= ~parpadeo_q;
    end else begin
      div_cnt_q  <= div_cnt_q + 32'd1;
    end
  end

  assign parpadeo = (estado_q == REPOSO) ? 1'b1 : parpadeo_q;
`endif

endmodule

// File: tb/tb_editor_hora.sv
// Self-checking bench for editor_hora (default build, 24 h hours field).
module tb_editor_hora;

  localparam logic [7:0] HMAX = 8'h23;
  localparam logic [7:0] HMIN = 8'h00;

  logic       clk;
  logic       reset;
  logic       btn_prog, btn_arriba, btn_abajo, btn_izq, btn_der;
  logic [7:0] hora_rtc, min_rtc, seg_rtc;
  logic [7:0] hora_out, min_out, seg_out;
  logic [1:0] campo_sel;
  logic       modo_prog, escribir;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edited time as BCD bytes, cursor as 0..2.
  logic [7:0] m_h, m_m, m_s;
  int         m_campo;

  editor_hora #(.HORA_MAX(HMAX), .MIN_HORA(HMIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_prog   (btn_prog),
    .btn_arriba (btn_arriba),
    .btn_abajo  (btn_abajo),
    .btn_izq    (btn_izq),
    .btn_der    (btn_der),
    .hora_rtc   (hora_rtc),
    .min_rtc    (min_rtc),
    .seg_rtc    (seg_rtc),
    .hora_out   (hora_out),
    .min_out    (min_out),
    .seg_out    (seg_out),
    .campo_sel  (campo_sel),
    .modo_prog  (modo_prog),
    .escribir   (escribir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input int campo, input logic modo,
                         input logic escr);
    chk({tag, ".hora"}, hora_out, h);
    chk({tag, ".min"}, min_out, m);
    chk({tag, ".seg"}, seg_out, s);
    chk({tag, ".campo"}, 8'(campo_sel), 8'(campo));
    chk({tag, ".modo"}, 8'(modo_prog), 8'(modo));
    chk({tag, ".escribir"}, 8'(escribir), 8'(escr));
  endtask

  function automatic logic [7:0] to_bcd(input int d);
    return 8'(((d / 10) * 16) + (d % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Field step in decimal: wrap at the limits, non-BCD snaps to the minimum.
  function automatic logic [7:0] m_step(input logic [7:0] v, input logic [7:0] mx,
                                        input logic [7:0] mn, input bit up);
    int d, dmx, dmn;
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) return mn;
    d   = from_bcd(v);
    dmx = from_bcd(mx);
    dmn = from_bcd(mn);
    if ((d > dmx) || (d < dmn)) return mn;
    if (up) return (d == dmx) ? mn : to_bcd(d + 1);
    return (d == dmn) ? mx : to_bcd(d - 1);
  endfunction

  // Random field value: mostly legal, sometimes with a units nibble above 9.
  function automatic logic [7:0] rnd_field(input int mind, input int maxd);
    if ($urandom_range(0, 3) == 0)
      return {4'($urandom_range(0, 15)), 4'($urandom_range(10, 15))};
    return to_bcd(int'($urandom_range(maxd, mind)));
  endfunction

  task automatic m_edit(input bit u, input bit d, input bit l, input bit r);
    if (u || d) begin
      case (m_campo)
        2:       m_h = m_step(m_h, HMAX, HMIN, u);
        1:       m_m = m_step(m_m, 8'h59, 8'h00, u);
        default: m_s = m_step(m_s, 8'h59, 8'h00, u);
      endcase
    end else if (l) begin
      m_campo = (m_campo + 1) % 3;
    end else if (r) begin
      m_campo = (m_campo + 2) % 3;
    end
  endtask

  task automatic pulse(input bit p, input bit u, input bit d, input bit l, input bit r);
    btn_prog = p; btn_arriba = u; btn_abajo = d; btn_izq = l; btn_der = r;
    @(posedge clk);
    #1;
    btn_prog = 0; btn_arriba = 0; btn_abajo = 0; btn_izq = 0; btn_der = 0;
  endtask

  task automatic edit_step(input string tag, input bit u, input bit d, input bit l,
                           input bit r);
    pulse(0, u, d, l, r);
    m_edit(u, d, l, r);
    chk_all(tag, m_h, m_m, m_s, m_campo, 1'b1, 1'b0);
  endtask

  task automatic enter_prog(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    hora_rtc = h; min_rtc = m; seg_rtc = s;
    pulse(1, 0, 0, 0, 0);
    chk({tag, ".carga_modo"}, 8'(modo_prog), 8'h01);
    chk({tag, ".carga_escr"}, 8'(escribir), 8'h00);
    @(posedge clk);
    #1;
    m_h = h; m_m = m; m_s = s; m_campo = 0;
    hora_rtc = to_bcd(int'($urandom_range(23, 0)));
    min_rtc  = to_bcd(int'($urandom_range(59, 0)));
    seg_rtc  = to_bcd(int'($urandom_range(59, 0)));
    #1;
    chk_all({tag, ".editar"}, m_h, m_m, m_s, 0, 1'b1, 1'b0);
  endtask

  task automatic exit_prog(input string tag, input bit with_up);
    pulse(1, with_up, 0, 0, 0);
    chk_all({tag, ".escribir"}, m_h, m_m, m_s, m_campo, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_all({tag, ".reposo"}, hora_rtc, min_rtc, seg_rtc, m_campo, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    btn_prog = 0; btn_arriba = 0; btn_abajo = 0; btn_izq = 0; btn_der = 0;
    hora_rtc = 8'h12; min_rtc = 8'h34; seg_rtc = 8'h56;
    m_h = 8'h00; m_m = 8'h00; m_s = 8'h00; m_campo = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 8'h12, 8'h34, 8'h56, 0, 1'b0, 1'b0);

    // Transparent display; edit buttons ignored outside programming mode.
    hora_rtc = 8'h01; min_rtc = 8'h02; seg_rtc = 8'h03;
    #1;
    chk_all("transp", 8'h01, 8'h02, 8'h03, 0, 1'b0, 1'b0);
    pulse(0, 1, 1, 1, 1);
    chk_all("ignored", 8'h01, 8'h02, 8'h03, 0, 1'b0, 1'b0);

    // Seconds wrap 58 -> 59 -> 00 -> 01.
    enter_prog("load1", 8'h23, 8'h09, 8'h58);
    for (int i = 0; i < 3; i++) edit_step("seg_up", 1, 0, 0, 0);
    chk("seg01", seg_out, 8'h01);

    // Hours wrap both ways.
    edit_step("izq", 0, 0, 1, 0);
    edit_step("izq", 0, 0, 1, 0);
    edit_step("hora_up", 1, 0, 0, 0);
    chk("hora00", hora_out, 8'h00);
    edit_step("hora_dn", 0, 1, 0, 0);
    edit_step("hora_dn", 0, 1, 0, 0);
    chk("hora22", hora_out, 8'h22);

    // Minutes: arriba wins over abajo, carry 09 -> 10.
    edit_step("der", 0, 0, 0, 1);
    edit_step("min_both", 1, 1, 0, 0);
    chk("min10", min_out, 8'h10);

    // btn_prog beats btn_arriba.
    exit_prog("exit_prio", 1);

    // Edit to 07:00:00 and commit.
    enter_prog("load2", 8'h07, 8'h00, 8'h59);
    edit_step("seg_wrap", 1, 0, 0, 0);
    exit_prog("commit", 0);
    @(posedge clk);
    #1;
    chk("escr_once", 8'(escribir), 8'h00);

    // Non-BCD latch snaps to field minimum.
    enter_prog("load3", 8'h2F, 8'hA5, 8'h5A);
    edit_step("seg_clamp", 0, 1, 0, 0);
    edit_step("der", 0, 0, 0, 1);
    edit_step("hora_clamp", 1, 0, 0, 0);
    exit_prog("exit3", 0);

    // Random editing sessions against the model.
    for (int k = 0; k < 4; k++) begin
      enter_prog("rload", rnd_field(0, 23), rnd_field(0, 59), rnd_field(0, 59));
      for (int i = 0; i < 60; i++) begin
        edit_step("rand", bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0));
      end
      exit_prog("rexit", bit'($urandom_range(0, 1)));
    end

    // Reset mid-edit abandons the edit without a write request.
    enter_prog("load4", 8'h10, 8'h20, 8'h30);
    edit_step("izq", 0, 0, 1, 0);
    edit_step("min_up", 1, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("mid_reset", hora_rtc, min_rtc, seg_rtc, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_write", 8'(escribir), 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
